branch_resolver: RTL

Sequential branch-condition unit that acts as the initiator toward the 32-bit ALU. It accepts a conditional-branch request and drives the ALU with a subtract of the two register operands. It then captures the ALU's {NEGATIVE, OVERFLOW, ZERO} status and returns a taken/not-taken decision plus the next PC over a valid/ready handshake. It sits between decode and the PC-update logic of the RISC-V core.

---
 rtl/branch_resolver_if.sv | 44 ++++
 rtl/branch_resolver.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/branch_resolver_if.sv
// -----------------------------------------------------------------------------
// branch_resolver_if
// Bundles the three channels of the branch resolver:
//   request  : req_valid/req_ready handshake plus funct3, operands, pc, imm
//   ALU      : alu_a, alu_b, alu_op toward the ALU, alu_status {N,V,Z} back
//   response : resp_valid/resp_ready handshake plus taken, target, illegal
// Modports:
//   master : environment side (decode, ALU status source, PC-update consumer)
//   slave  : branch_resolver side
// -----------------------------------------------------------------------------
interface branch_resolver_if;
    logic        req_valid;
    logic        req_ready;
    logic [2:0]  req_funct3;
    logic [31:0] req_rs1;
    logic [31:0] req_rs2;
    logic [31:0] req_pc;
    logic [31:0] req_imm;

    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [3:0]  alu_op;
    logic [2:0]  alu_status;

    logic        resp_valid;
    logic        resp_ready;
    logic        resp_taken;
    logic [31:0] resp_target;
    logic        resp_illegal;

    modport master (
        output req_valid, req_funct3, req_rs1, req_rs2, req_pc, req_imm,
        output alu_status, resp_ready,
        input  req_ready, alu_a, alu_b, alu_op,
        input  resp_valid, resp_taken, resp_target, resp_illegal
    );

    modport slave (
        input  req_valid, req_funct3, req_rs1, req_rs2, req_pc, req_imm,
        input  alu_status, resp_ready,
        output req_ready, alu_a, alu_b, alu_op,
        output resp_valid, resp_taken, resp_target, resp_illegal
    );
endinterface

// File: rtl/branch_resolver.sv
// -----------------------------------------------------------------------------
// branch_resolver
// Resolves RV32I conditional branches by issuing a subtract to the ALU and
// decoding its {N,V,Z} status into a taken/not-taken decision and next PC.
// Ports:
//   clk   : clock, rising edge
//   reset : asynchronous, active-high
//   bus   : branch_resolver_if.slave (request, ALU and response channels)
// All outputs are registered; they are computed from the next state so that
// they line up with the state they belong to.
// -----------------------------------------------------------------------------
module branch_resolver #(
    parameter logic [3:0]  ALU_SUB_OP  = 4'b0001,
    parameter int unsigned ALU_LATENCY = 1
) (
    input  logic             clk,
    input  logic             reset,
    branch_resolver_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        EXEC = 2'b01,
        RESP = 2'b10
    } state_t;

    localparam logic [3:0] CNT_RELOAD = 4'(ALU_LATENCY - 1);

    state_t      state_r;
    state_t      state_next_s;
    logic [3:0]  cnt_r;
    logic [2:0]  funct3_r;
    logic [31:0] rs1_r;
    logic [31:0] rs2_r;
    logic [31:0] tgt_taken_r;
    logic [31:0] tgt_seq_r;

    logic        req_ready_r;
    logic        resp_valid_r;
    logic        resp_taken_r;
    logic [31:0] resp_target_r;
    logic        resp_illegal_r;
    logic [31:0] alu_a_r;
    logic [31:0] alu_b_r;
    logic [3:0]  alu_op_r;

    logic        accept_s;
    logic        illegal_s;
    logic        taken_s;
    logic [2:0]  op_funct3_s;
    logic [31:0] op_a_s;
    logic [31:0] op_b_s;
    logic [31:0] sign_flip_s;
    logic [31:0] alu_a_next_s;
    logic [31:0] alu_b_next_s;
    logic [3:0]  alu_op_next_s;

    // funct3 010 and 011 have no branch meaning in RV32I.
    function automatic logic funct3_illegal(input logic [2:0] f3);
        return (f3[2:1] == 2'b01);
    endfunction

    // Branch condition from ALU status {N,V,Z}; lt is the signed less-than.
    function automatic logic branch_taken(input logic [2:0] f3, input logic [2:0] st);
        logic lt;
        lt = st[2] ^ st[1];
        case (f3)
            3'b000:          return st[0];
            3'b001:          return ~st[0];
            3'b100, 3'b110:  return lt;
            3'b101, 3'b111:  return ~lt;
            default:         return 1'b0;
        endcase
    endfunction

    assign accept_s  = (state_r == IDLE) && bus.req_valid;
    assign illegal_s = funct3_illegal(bus.req_funct3);
    assign taken_s   = branch_taken(funct3_r, bus.alu_status);

    // Next-state logic for the IDLE/EXEC/RESP sequencer.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE: begin
                if (bus.req_valid) begin
                    state_next_s = illegal_s ? RESP : EXEC;
                end else begin
                    state_next_s = IDLE;
                end
            end
            EXEC: begin
                if (cnt_r == 4'd0) begin
                    state_next_s = RESP;
                end else begin
                    state_next_s = EXEC;
                end
            end
            RESP: begin
                if (bus.resp_ready) begin
                    state_next_s = IDLE;
                end else begin
                    state_next_s = RESP;
                end
            end
            default: state_next_s = IDLE;
        endcase
    end

    // ALU drive for the coming cycle: on the accept edge the operands come
    // straight from the request, afterwards from the captured copies. Flipping
    // the sign bits turns the ALU's signed compare into an unsigned one.
    always_comb begin
        alu_a_next_s  = 32'd0;
        alu_b_next_s  = 32'd0;
        alu_op_next_s = 4'b0000;
        if (state_r == IDLE) begin
            op_funct3_s = bus.req_funct3;
            op_a_s      = bus.req_rs1;
            op_b_s      = bus.req_rs2;
        end else begin
            op_funct3_s = funct3_r;
            op_a_s      = rs1_r;
            op_b_s      = rs2_r;
        end
        sign_flip_s = op_funct3_s[1] ? 32'h8000_0000 : 32'h0000_0000;
        if (state_next_s == EXEC) begin
            alu_a_next_s  = op_a_s ^ sign_flip_s;
            alu_b_next_s  = op_b_s ^ sign_flip_s;
            alu_op_next_s = ALU_SUB_OP;
        end else begin
            alu_a_next_s  = 32'd0;
            alu_b_next_s  = 32'd0;
            alu_op_next_s = 4'b0000;
        end
    end

    // State, request capture, EXEC counter and registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r        <= IDLE;
            cnt_r          <= 4'd0;
            funct3_r       <= 3'b000;
            rs1_r          <= 32'd0;
            rs2_r          <= 32'd0;
            tgt_taken_r    <= 32'd0;
            tgt_seq_r      <= 32'd0;
            req_ready_r    <= 1'b1;
            resp_valid_r   <= 1'b0;
            resp_taken_r   <= 1'b0;
            resp_target_r  <= 32'd0;
            resp_illegal_r <= 1'b0;
            alu_a_r        <= 32'd0;
            alu_b_r        <= 32'd0;
            alu_op_r       <= 4'b0000;
        end else begin
            state_r      <= state_next_s;
            req_ready_r  <= (state_next_s == IDLE);
            resp_valid_r <= (state_next_s == RESP);
            alu_a_r      <= alu_a_next_s;
            alu_b_r      <= alu_b_next_s;
            alu_op_r     <= alu_op_next_s;
            if (accept_s) begin
                funct3_r    <= bus.req_funct3;
                rs1_r       <= bus.req_rs1;
                rs2_r       <= bus.req_rs2;
                tgt_taken_r <= bus.req_pc + bus.req_imm;
                tgt_seq_r   <= bus.req_pc + 32'd4;
                if (illegal_s) begin
                    resp_taken_r   <= 1'b0;
                    resp_target_r  <= bus.req_pc + 32'd4;
                    resp_illegal_r <= 1'b1;
                end else begin
                    cnt_r <= CNT_RELOAD;
                end
            end else if (state_r == EXEC) begin
                if (cnt_r == 4'd0) begin
                    resp_taken_r  <= taken_s;
                    resp_target_r <= taken_s ? tgt_taken_r : tgt_seq_r;
                end else begin
                    cnt_r <= cnt_r - 4'd1;
                end
            end else if ((state_r == RESP) && bus.resp_ready) begin
                resp_illegal_r <= 1'b0;
            end
        end
    end

    assign bus.req_ready    = req_ready_r;
    assign bus.resp_valid   = resp_valid_r;
    assign bus.resp_taken   = resp_taken_r;
    assign bus.resp_target  = resp_target_r;
    assign bus.resp_illegal = resp_illegal_r;
    assign bus.alu_a        = alu_a_r;
    assign bus.alu_b        = alu_b_r;
    assign bus.alu_op       = alu_op_r;

endmodule
